// File: rtl/rf_wport_arb_pkg.sv
// Types shared by the regfile write-port arbiter, its queue and its interface.
`include "defines.v"

package rf_wport_arb_pkg;
  localparam int AW = `RADDR_WIDTH;
  localparam int DW = `RDATA_WIDTH;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_WB,
    GNT_QUEUE
  } gnt_e;
endpackage

// File: rtl/rf_wport_arb_if.sv
// Bus bundle between the pipeline/secondary unit and the regfile write-port arbiter.
interface rf_wport_arb_if;
  import rf_wport_arb_pkg::*;

  logic          wb_we_i;
  logic [AW-1:0] wb_waddr_i;
  logic [DW-1:0] wb_wdata_i;
  logic          sec_valid_i;
  logic [AW-1:0] sec_waddr_i;
  logic [DW-1:0] sec_wdata_i;
  logic          sec_ready_o;
  logic          rf_we_o;
  logic [AW-1:0] rf_waddr_o;
  logic [DW-1:0] rf_wdata_o;
  logic          wb_stall_o;
  logic [AW-1:0] raddr1_i;
  logic [AW-1:0] raddr2_i;
  logic          pend1_o;
  logic          pend2_o;

  modport slave (
    input  wb_we_i, wb_waddr_i, wb_wdata_i,
    input  sec_valid_i, sec_waddr_i, sec_wdata_i,
    input  raddr1_i, raddr2_i,
    output sec_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    output wb_stall_o, pend1_o, pend2_o
  );

  modport master (
    output wb_we_i, wb_waddr_i, wb_wdata_i,
    output sec_valid_i, sec_waddr_i, sec_wdata_i,
    output raddr1_i, raddr2_i,
    input  sec_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
    input  wb_stall_o, pend1_o, pend2_o
  );
endinterface

// File: rtl/defines.v
// Shared register-file widths and encodings for the write-port arbiter.
`ifndef RF_DEFINES_V
`define RF_DEFINES_V
`define RADDR_WIDTH   5
`define RDATA_WIDTH   32
`define ZERO_REG      5'd0
`define ZERO          32'd0
`define WRITE_ENABLE  1'b1
`define RF_STARVE_MAX 4
`endif

// File: rtl/rf_wq_fifo.sv
// Secondary write queue: FIFO storage with per-entry valid bits and
// per-entry address compare against the two ID read ports.
module rf_wq_fifo
  import rf_wport_arb_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  wr_req_t           push_req_i,
  input  logic              pop_i,
  output wr_req_t           head_o,
  output logic              empty_o,
  output logic              full_o,
  input  logic [AW-1:0]     maddr1_i,
  input  logic [AW-1:0]     maddr2_i,
  output logic [QDEPTH-1:0] match1_o,
  output logic [QDEPTH-1:0] match2_o
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  wr_req_t [QDEPTH-1:0] mem_q, mem_d;
  logic    [QDEPTH-1:0] vld_q, vld_d;
  logic    [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic    [PW:0]       cnt_q, cnt_d;
  logic                 push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(QDEPTH));
  assign head_o  = mem_q[rptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d  = mem_q;
    vld_d  = vld_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    // Push never targets the popped slot: pushes are refused while full.
    if (push_ok) begin
      mem_d[wptr_q] = push_req_i;
      vld_d[wptr_q] = 1'b1;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop_ok) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = rptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q  <= '0;
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      vld_q  <= vld_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // The head stays valid through its dequeue cycle, so it still matches.
  for (genvar i = 0; i < QDEPTH; i++) begin : g_match
    assign match1_o[i] = vld_q[i] && (mem_q[i].addr == maddr1_i);
    assign match2_o[i] = vld_q[i] && (mem_q[i].addr == maddr2_i);
  end
endmodule

// File: rtl/rf_wport_arb.sv
// Regfile write-port arbiter: WB stage has priority, secondary writes queue
// behind it and force a one-cycle WB stall once the queue head starves.
`include "defines.v"

module rf_wport_arb
  import rf_wport_arb_pkg::*;
#(
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = `RF_STARVE_MAX
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rf_wport_arb_if.slave  bus
);
  localparam int CW = $clog2(STARVE_MAX + 1) > 0 ? $clog2(STARVE_MAX + 1) : 1;

  logic [CW-1:0]     age_q, age_d;
  logic              stall_q, stall_d;
  gnt_e              gnt;
  wr_req_t           head, push_req;
  logic              q_empty, q_full, push, pop, wb_act;
  logic [QDEPTH-1:0] m1, m2;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;

  assign wb_act   = (bus.wb_we_i == `WRITE_ENABLE) && (bus.wb_waddr_i != `ZERO_REG);
  assign push_req = '{addr: bus.sec_waddr_i, data: bus.sec_wdata_i};
  // Writes to x0 complete the handshake but never occupy a slot.
  assign push     = bus.sec_valid_i & ~q_full & (bus.sec_waddr_i != `ZERO_REG);
  assign pop      = (gnt == GNT_QUEUE);

  rf_wq_fifo #(.QDEPTH(QDEPTH)) u_wq (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_req_i (push_req),
    .pop_i      (pop),
    .head_o     (head),
    .empty_o    (q_empty),
    .full_o     (q_full),
    .maddr1_i   (bus.raddr1_i),
    .maddr2_i   (bus.raddr2_i),
    .match1_o   (m1),
    .match2_o   (m2)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (!rst_i)                  gnt = GNT_NONE;
    else if (stall_q && !q_empty) gnt = GNT_QUEUE;
    else if (wb_act)             gnt = GNT_WB;
    else if (!q_empty)           gnt = GNT_QUEUE;
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = `ZERO_REG;
    rf_wdata = `ZERO;
    case (gnt)
      GNT_WB: begin
        rf_we    = 1'b1;
        rf_waddr = bus.wb_waddr_i;
        rf_wdata = bus.wb_wdata_i;
      end
      GNT_QUEUE: begin
        rf_we    = 1'b1;
        rf_waddr = head.addr;
        rf_wdata = head.data;
      end
      default: ;
    endcase
  end

  always_comb begin
    age_d = age_q;
    if (q_empty || pop)
      age_d = '0;
    else if (age_q != CW'(STARVE_MAX))
      age_d = age_q + 1'b1;
    // Stall lands the cycle after the head's wait count saturates.
    stall_d = !stall_q && (age_d == CW'(STARVE_MAX));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      age_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      age_q   <= age_d;
      stall_q <= stall_d;
    end
  end

  assign bus.sec_ready_o = ~q_full;
  assign bus.rf_we_o     = rf_we;
  assign bus.rf_waddr_o  = rf_waddr;
  assign bus.rf_wdata_o  = rf_wdata;
  assign bus.wb_stall_o  = stall_q;
  assign bus.pend1_o     = (bus.raddr1_i != `ZERO_REG) && (|m1);
  assign bus.pend2_o     = (bus.raddr2_i != `ZERO_REG) && (|m2);
endmodule

// File: doc/rf_wport_arb.md
RF_WPORT_ARB -- requirements
Module: rf_wport_arb

Interface
REQ-001 SHALL have parameter QDEPTH, default 2: secondary write-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter STARVE_MAX, default 4: cycles a queued write waits before forcing a WB stall.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports wb_we_i / wb_waddr_i / wb_wdata_i  input  1/`RADDR_WIDTH/`RDATA_WIDTH  WB-stage write; no backpressure.
REQ-006 SHALL have ports sec_valid_i / sec_waddr_i / sec_wdata_i  input  1/`RADDR_WIDTH/`RDATA_WIDTH  secondary (long-latency unit) write request.
REQ-007 SHALL have port sec_ready_o  output  1  secondary request accepted when sec_valid_i & sec_ready_o.
REQ-008 SHALL have ports rf_we_o / rf_waddr_o / rf_wdata_o  output  1/`RADDR_WIDTH/`RDATA_WIDTH  to regfile write port.
REQ-009 SHALL have port wb_stall_o  output  1  registered; pipeline holds WB stage contents while high.
REQ-010 SHALL have ports raddr1_i / raddr2_i  input  `RADDR_WIDTH  ID read addresses.
REQ-011 SHALL have ports pend1_o / pend2_o  output  1  read address matches a queued, unwritten secondary write.

Function
REQ-012 SHALL define WB request active as wb_we_i==`WRITE_ENABLE and wb_waddr_i!=`ZERO_REG.
REQ-013 SHALL drive sec_ready_o = queue not full; no combinational path from sec_valid_i to sec_ready_o.
REQ-014 SHALL enqueue accepted secondary writes in FIFO order; waddr==`ZERO_REG accepted and discarded (not enqueued).
REQ-015 SHALL grant, combinationally each cycle: wb_stall_o=1 -> queue head; else WB active -> WB; else queue non-empty -> queue head; else rf_we_o=0.
REQ-016 SHALL dequeue the head in the same cycle it is granted; earliest regfile write of an accepted secondary request is the cycle after acceptance (latency 1).
REQ-017 SHALL, with rf_we_o=0, drive rf_waddr_o=`ZERO_REG and rf_wdata_o=`ZERO.
REQ-018 SHALL keep an age counter: cleared when queue empty or head dequeued; incremented each cycle head waits; saturates at STARVE_MAX.
REQ-019 SHALL assert wb_stall_o for exactly one cycle in the cycle after the counter reaches STARVE_MAX; WB inputs are ignored during that cycle.
REQ-020 SHALL not reassert wb_stall_o on back-to-back cycles; counter restarts from 0 for the new head.
REQ-021 SHALL, on same-cycle enqueue and dequeue when full, keep sec_ready_o low (decision uses pre-cycle occupancy); enqueue and dequeue when not full both complete.
REQ-022 SHALL assert pendN_o when raddrN_i!=`ZERO_REG and equals waddr of any valid queue entry, including the entry being dequeued that cycle.
REQ-023 SHALL, when WB and a queued entry target the same register, order by grant: later write wins; no merging.

Reset
REQ-024 SHALL on rst_i low: queue empty, pointers 0, age counter 0, wb_stall_o=0, sec_ready_o=1, rf_we_o=0, pend1_o=pend2_o=0.
REQ-025 SHALL discard queued writes on reset mid-operation; no regfile write issued while rst_i low.
REQ-026 SHALL resume accepting in the first clock after rst_i deasserts.

Structure
REQ-027 SHALL take `RADDR_WIDTH, `RDATA_WIDTH, `ZERO_REG, `ZERO, `WRITE_ENABLE from defines.v; add `RF_STARVE_MAX default there.
REQ-028 SHALL place the queue in sub-module rf_wq_fifo (storage, pointers, count, per-entry address match outputs).

Verification
REQ-029 SHALL verify: sec write x5=0x11 alone, WB idle -> rf_we_o=1, waddr 5, data 0x11 one cycle after accept.
REQ-030 SHALL verify: WB writes x3 every cycle, sec x7=0xAA queued -> wb_stall_o high 5 cycles after accept; x7 written in that cycle, WB ignored.
REQ-031 SHALL verify: three sec requests, WB busy, QDEPTH=2 -> sec_ready_o low after second; third accepted after first drain.
REQ-032 SHALL verify: sec write to x0 -> accepted, no rf_we_o, pend outputs stay 0.
REQ-033 SHALL verify: queue holds x9, raddr1_i=9, raddr2_i=0 -> pend1_o=1, pend2_o=0 until x9 written.
REQ-034 SHALL verify: rst_i low with two queued entries -> no write follows, sec_ready_o=1, wb_stall_o=0.
